// File: rtl/next_pc_unit.sv
// Program-counter register and next-PC selection for an RV32I fetch stage.
// Resolves branch conditions, JAL/JALR targets and alignment, and counts accepted redirects.
module next_pc_unit #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int              IALIGN       = 4,
  parameter int              CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             br_valid,
  input  logic [2:0]       br_op,
  input  logic             jump,
  input  logic             jalr,
  input  logic [XLEN-1:0]  rs1_val,
  input  logic [XLEN-1:0]  rs2_val,
  input  logic [XLEN-1:0]  imm,
  output logic [XLEN-1:0]  pc,
  output logic [XLEN-1:0]  pc_plus,
  output logic             taken,
  output logic             flush,
  output logic             misalign,
  output logic [CNT_W-1:0] taken_cnt
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    if (&c) return c;
    return c + CNT_W'(1);
  endfunction

  logic signed [XLEN-1:0] rs1_s;
  logic signed [XLEN-1:0] rs2_s;
  logic                   cond;
  logic [XLEN-1:0]        jalr_sum;
  logic [XLEN-1:0]        target;
  logic                   bad_align;

  assign rs1_s = rs1_val;
  assign rs2_s = rs2_val;

  always_comb begin
    cond = 1'b0;
    case (br_op)
      3'b000:  cond = (rs1_val == rs2_val);
      3'b001:  cond = (rs1_val != rs2_val);
      3'b100:  cond = (rs1_s < rs2_s);
      3'b101:  cond = !(rs1_s < rs2_s);
      3'b110:  cond = (rs1_val < rs2_val);
      3'b111:  cond = !(rs1_val < rs2_val);
      default: cond = 1'b0;
    endcase
  end

  assign pc_plus  = pc + XLEN'(4);
  assign taken    = jump | jalr | (br_valid & cond);
  assign jalr_sum = rs1_val + imm;

  // JAL and a taken branch share the pc-relative target, so only JALR needs priority.
  assign target    = jalr ? {jalr_sum[XLEN-1:1], 1'b0} : (pc + imm);
  assign bad_align = (IALIGN == 4) ? (target[1:0] != 2'b00) : target[0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc        <= RESET_VECTOR;
      flush     <= 1'b0;
      misalign  <= 1'b0;
      taken_cnt <= '0;
    end else if (stall) begin
      flush    <= 1'b0;
      misalign <= 1'b0;
    end else if (taken && !bad_align) begin
      pc        <= target;
      flush     <= 1'b1;
      misalign  <= 1'b0;
      taken_cnt <= sat_inc(taken_cnt);
    end else begin
      pc       <= pc_plus;
      flush    <= 1'b0;
      misalign <= taken;
    end
  end

endmodule

// File: tb/tb_next_pc_unit.sv
// Directed scoreboard bench for next_pc_unit (XLEN=32, IALIGN=4, CNT_W=2).
module tb_next_pc_unit;

  typedef struct packed {
    logic [31:0] pc;
    logic        flush;
    logic        mis;
    logic [1:0]  cnt;
  } exp_t;

  typedef struct packed {
    logic        stall;
    logic        bv;
    logic [2:0]  op;
    logic        jump;
    logic        jalr;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] imm;
    logic        tk;
  } stim_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, br_valid, jump, jalr;
  logic [2:0]  br_op;
  logic [31:0] rs1_val, rs2_val, imm;
  logic [31:0] pc, pc_plus;
  logic        taken, flush, misalign;
  logic [1:0]  taken_cnt;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  next_pc_unit #(.XLEN(32), .RESET_VECTOR(32'h0), .IALIGN(4), .CNT_W(2)) dut (
    .clk(clk), .rst(rst), .stall(stall), .br_valid(br_valid), .br_op(br_op),
    .jump(jump), .jalr(jalr), .rs1_val(rs1_val), .rs2_val(rs2_val), .imm(imm),
    .pc(pc), .pc_plus(pc_plus), .taken(taken), .flush(flush),
    .misalign(misalign), .taken_cnt(taken_cnt)
  );

  always #5 clk = ~clk;

  function automatic stim_t S(input logic st, input logic bv, input logic [2:0] op,
                              input logic j, input logic jr, input logic [31:0] a,
                              input logic [31:0] b, input logic [31:0] i, input logic tk);
    return '{stall: st, bv: bv, op: op, jump: j, jalr: jr, rs1: a, rs2: b, imm: i, tk: tk};
  endfunction

  function automatic exp_t E(input logic [31:0] p, input logic f, input logic m,
                             input logic [1:0] c);
    return '{pc: p, flush: f, mis: m, cnt: c};
  endfunction

  task automatic apply(input stim_t s);
    stall = s.stall; br_valid = s.bv; br_op = s.op; jump = s.jump; jalr = s.jalr;
    rs1_val = s.rs1; rs2_val = s.rs2; imm = s.imm;
  endtask

  task automatic clk_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    apply(S(0, 0, 3'b000, 0, 0, 0, 0, 0, 0));
    rst = 1'b0;
    #2;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    exp_t e, got;
    apply(S(0, 0, 3'b000, 0, 0, 0, 0, 0, 0));
    rst = 1'b0;
    clk_step();
    clk_step();
    sb.push_back(E(32'h0, 0, 0, 2'd0));
    got = {pc, flush, misalign, taken_cnt};
    e = sb.pop_front();
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL reset_hold got %h exp %h", got, e);
    end
    #2 rst = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      sb.push_back(E(32'(4 * i), 0, 0, 2'd0));
      clk_step();
      got = {pc, flush, misalign, taken_cnt};
      e = sb.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL reset_run[%0d] got %h exp %h", i, got, e);
      end
    end
  endtask

  task automatic test_beq();
    stim_t st[$];
    exp_t ex[$];
    exp_t e, got;
    logic [31:0] prev_pc = 32'h0;
    do_reset();
    st.push_back(S(0, 0, 3'b000, 1, 0, 0, 0, 32'h100, 1));      ex.push_back(E(32'h100, 1, 0, 1));
    st.push_back(S(0, 1, 3'b000, 0, 0, 5, 5, 32'h10, 1));       ex.push_back(E(32'h110, 1, 0, 2));
    st.push_back(S(0, 0, 3'b000, 0, 0, 0, 0, 0, 0));            ex.push_back(E(32'h114, 0, 0, 2));
    st.push_back(S(0, 0, 3'b000, 1, 0, 0, 0, 32'hFFFFFFEC, 1)); ex.push_back(E(32'h100, 1, 0, 3));
    st.push_back(S(0, 1, 3'b000, 0, 0, 5, 6, 32'h10, 0));       ex.push_back(E(32'h104, 0, 0, 3));
    st.push_back(S(0, 1, 3'b001, 0, 0, 5, 6, 32'h10, 1));       ex.push_back(E(32'h114, 1, 0, 3));
    st.push_back(S(0, 1, 3'b001, 0, 0, 7, 7, 32'h10, 0));       ex.push_back(E(32'h118, 0, 0, 3));
    foreach (st[i]) begin
      apply(st[i]);
      sb.push_back(ex[i]);
      #1;
      checks++;
      if (taken !== st[i].tk) begin
        errors++;
        $display("FAIL beq_taken[%0d] got %b exp %b", i, taken, st[i].tk);
      end
      clk_step();
      got = {pc, flush, misalign, taken_cnt};
      e = sb.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL beq_state[%0d] got %h exp %h", i, got, e);
      end
      prev_pc = e.pc;
    end
    checks++;
    if (pc_plus !== prev_pc + 32'd4) begin
      errors++;
      $display("FAIL beq_pc_plus got %h exp %h", pc_plus, prev_pc + 32'd4);
    end
  endtask

  task automatic test_conditions();
    stim_t st[$];
    exp_t ex[$];
    exp_t e, got;
    do_reset();
    st.push_back(S(0, 1, 3'b100, 0, 0, 32'hFFFFFFFF, 1, 8, 1));            ex.push_back(E(32'h08, 1, 0, 1));
    st.push_back(S(0, 1, 3'b101, 0, 0, 32'hFFFFFFFF, 1, 8, 0));            ex.push_back(E(32'h0C, 0, 0, 1));
    st.push_back(S(0, 1, 3'b110, 0, 0, 32'hFFFFFFFF, 1, 8, 0));            ex.push_back(E(32'h10, 0, 0, 1));
    st.push_back(S(0, 1, 3'b111, 0, 0, 32'hFFFFFFFF, 1, 8, 1));            ex.push_back(E(32'h18, 1, 0, 2));
    st.push_back(S(0, 1, 3'b010, 0, 0, 32'hFFFFFFFF, 1, 8, 0));            ex.push_back(E(32'h1C, 0, 0, 2));
    st.push_back(S(0, 1, 3'b011, 0, 0, 32'hFFFFFFFF, 1, 8, 0));            ex.push_back(E(32'h20, 0, 0, 2));
    st.push_back(S(0, 0, 3'b000, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 8, 0)); ex.push_back(E(32'h24, 0, 0, 2));
    st.push_back(S(0, 1, 3'b101, 0, 0, 1, 32'hFFFFFFFF, 8, 1));            ex.push_back(E(32'h2C, 1, 0, 3));
    st.push_back(S(0, 1, 3'b110, 0, 0, 1, 32'hFFFFFFFF, 8, 1));            ex.push_back(E(32'h34, 1, 0, 3));
    foreach (st[i]) begin
      apply(st[i]);
      sb.push_back(ex[i]);
      #1;
      checks++;
      if (taken !== st[i].tk) begin
        errors++;
        $display("FAIL cond_taken[%0d] op=%b got %b exp %b", i, st[i].op, taken, st[i].tk);
      end
      clk_step();
      got = {pc, flush, misalign, taken_cnt};
      e = sb.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL cond_state[%0d] got %h exp %h", i, got, e);
      end
    end
  endtask

  task automatic test_jalr_align();
    stim_t st[$];
    exp_t ex[$];
    exp_t e, got;
    logic [31:0] prev_pc = 32'h0;
    do_reset();
    st.push_back(S(0, 0, 3'b000, 0, 1, 32'h203, 0, 0, 1));          ex.push_back(E(32'h004, 0, 1, 0));
    st.push_back(S(0, 0, 3'b000, 0, 0, 0, 0, 0, 0));                ex.push_back(E(32'h008, 0, 0, 0));
    st.push_back(S(0, 0, 3'b000, 0, 1, 32'h205, 0, 32'hFFFFFFFF, 1)); ex.push_back(E(32'h204, 1, 0, 1));
    st.push_back(S(0, 0, 3'b000, 1, 0, 0, 0, 2, 1));                ex.push_back(E(32'h208, 0, 1, 1));
    st.push_back(S(0, 1, 3'b000, 1, 1, 32'h300, 32'h300, 32'h40, 1)); ex.push_back(E(32'h340, 1, 0, 2));
    st.push_back(S(0, 0, 3'b000, 0, 1, 32'h301, 0, 0, 1));          ex.push_back(E(32'h300, 1, 0, 3));
    foreach (st[i]) begin
      apply(st[i]);
      sb.push_back(ex[i]);
      #1;
      checks++;
      if (pc_plus !== prev_pc + 32'd4) begin
        errors++;
        $display("FAIL jalr_link[%0d] got %h exp %h", i, pc_plus, prev_pc + 32'd4);
      end
      clk_step();
      got = {pc, flush, misalign, taken_cnt};
      e = sb.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL jalr_state[%0d] got %h exp %h", i, got, e);
      end
      prev_pc = e.pc;
    end
  endtask

  task automatic test_wrap_stall();
    stim_t st[$];
    exp_t ex[$];
    exp_t e, got;
    logic [31:0] prev_pc = 32'h0;
    do_reset();
    st.push_back(S(0, 0, 3'b000, 1, 0, 0, 0, 32'hFFFFFFFC, 1)); ex.push_back(E(32'hFFFFFFFC, 1, 0, 1));
    st.push_back(S(0, 0, 3'b000, 0, 0, 0, 0, 0, 0));            ex.push_back(E(32'h0, 0, 0, 1));
    st.push_back(S(1, 0, 3'b000, 1, 0, 0, 0, 32'h40, 1));       ex.push_back(E(32'h0, 0, 0, 1));
    st.push_back(S(1, 0, 3'b000, 1, 0, 0, 0, 32'h40, 1));       ex.push_back(E(32'h0, 0, 0, 1));
    st.push_back(S(0, 0, 3'b000, 1, 0, 0, 0, 32'h40, 1));       ex.push_back(E(32'h40, 1, 0, 2));
    st.push_back(S(1, 0, 3'b000, 0, 1, 32'h203, 0, 0, 1));      ex.push_back(E(32'h40, 0, 0, 2));
    st.push_back(S(0, 0, 3'b000, 0, 0, 0, 0, 0, 0));            ex.push_back(E(32'h44, 0, 0, 2));
    foreach (st[i]) begin
      apply(st[i]);
      sb.push_back(ex[i]);
      #1;
      checks++;
      if ({taken, pc_plus} !== {st[i].tk, prev_pc + 32'd4}) begin
        errors++;
        $display("FAIL wrap_comb[%0d] got taken=%b pc_plus=%h exp taken=%b pc_plus=%h",
                 i, taken, pc_plus, st[i].tk, prev_pc + 32'd4);
      end
      clk_step();
      got = {pc, flush, misalign, taken_cnt};
      e = sb.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL wrap_state[%0d] got %h exp %h", i, got, e);
      end
      prev_pc = e.pc;
    end
  endtask

  task automatic test_sat_reset();
    exp_t e, got;
    logic [1:0] c = 2'd0;
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      apply(S(0, 0, 3'b000, 1, 0, 0, 0, 32'h8, 1));
      if (c != 2'd3) c = c + 2'd1;
      sb.push_back(E(32'(8 * i), 1, 0, c));
      clk_step();
      got = {pc, flush, misalign, taken_cnt};
      e = sb.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL sat_state[%0d] got %h exp %h", i, got, e);
      end
    end
    apply(S(0, 0, 3'b000, 1, 0, 0, 0, 32'h100, 1));
    #1 rst = 1'b0;
    sb.push_back(E(32'h0, 0, 0, 2'd0));
    #1;
    got = {pc, flush, misalign, taken_cnt};
    e = sb.pop_front();
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL async_reset got %h exp %h", got, e);
    end
    apply(S(0, 0, 3'b000, 0, 0, 0, 0, 0, 0));
    #1 rst = 1'b1;
    sb.push_back(E(32'h4, 0, 0, 2'd0));
    clk_step();
    got = {pc, flush, misalign, taken_cnt};
    e = sb.pop_front();
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL post_reset got %h exp %h", got, e);
    end
  endtask

  initial begin
    rst = 1'b0;
    apply(S(0, 0, 3'b000, 0, 0, 0, 0, 0, 0));
    test_reset();
    test_beq();
    test_conditions();
    test_jalr_align();
    test_wrap_stall();
    test_sat_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule
